// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and
// multi-cycle multiply/divide freezes for a classic five-stage pipeline.
module hazard_ctrl #(
    parameter int unsigned MULDIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        id_branch_taken,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rt,
    input  logic        ex_muldiv_start,
    output logic        pc_en,
    output logic        if2id_en,
    output logic        if2id_flush,
    output logic        id2ex_en,
    output logic        id2ex_flush,
    output logic        busy,
    output logic [31:0] stall_count
);

    typedef enum logic {
        RUN,
        MD_WAIT
    } state_t;

    localparam logic [7:0] CNT_INIT = 8'(MULDIV_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        md_done_q, md_done_d;
    logic [31:0] stall_count_q, stall_count_d;

    logic load_use;
    logic md_go;

    // Register zero is hard-wired, so a load targeting it never creates a hazard.
    assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    // md_done masks the still-held start level for the one cycle the finished op leaves EX.
    assign md_go = (state_q == RUN) && ex_muldiv_start && !md_done_q;

    always_comb begin
        pc_en       = 1'b1;
        if2id_en    = 1'b1;
        if2id_flush = 1'b0;
        id2ex_en    = 1'b1;
        id2ex_flush = 1'b0;
        busy        = 1'b0;
        state_d     = state_q;
        cnt_d       = cnt_q;
        md_done_d   = 1'b0;

        if (!rst) begin
            unique case (state_q)
                RUN: begin
                    if (md_go) begin
                        pc_en    = 1'b0;
                        if2id_en = 1'b0;
                        id2ex_en = 1'b0;
                        state_d  = MD_WAIT;
                        cnt_d    = CNT_INIT;
                    end else if (load_use) begin
                        pc_en       = 1'b0;
                        if2id_en    = 1'b0;
                        id2ex_flush = 1'b1;
                    end else if (id_branch_taken) begin
                        if2id_flush = 1'b1;
                    end
                end
                MD_WAIT: begin
                    pc_en    = 1'b0;
                    if2id_en = 1'b0;
                    id2ex_en = 1'b0;
                    busy     = 1'b1;
                    cnt_d    = cnt_q - 8'd1;
                    // Exiting on cnt<=1 also guards against a stuck zero count.
                    if (cnt_q <= 8'd1) begin
                        state_d   = RUN;
                        md_done_d = 1'b1;
                    end
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (!pc_en && (stall_count_q != 32'hFFFF_FFFF)) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RUN;
            cnt_q         <= 8'd0;
            md_done_q     <= 1'b0;
            stall_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            md_done_q     <= md_done_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

endmodule
